// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit controller, the receiver and the
// transmit mux.
//   tx_state_t : transmit FSM state encoding
//   SEL_*      : transmit mux select codes (start / data / parity / stop-idle)
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_DATA  = 2'b01;
  localparam logic [1:0] SEL_PAR   = 2'b10;
  localparam logic [1:0] SEL_STOP  = 2'b11;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter. It counts 0..CLKS_PER_BIT-1 while i_run is high
// and then wraps. i_clear has priority and forces the count to 0.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clear        : synchronous clear
//   i_run          : count enable
//   o_count        : current count
//   o_bit_end      : high on the last cycle of a bit period (count == CLKS_PER_BIT-1)
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16,
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_run,
  output logic [CNT_W-1:0] o_count,
  output logic             o_bit_end
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_run) begin
      r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_bit_end = (r_count == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: sequencing controller for the UART transmit datapath. It accepts one
// byte per i_tx_start while idle and drives the shift register, the parity generator
// and the transmit mux.
//   i_tx_start, i_tx_data_in, i_parity_en : request, sampled only on accept in IDLE
//   o_data_q, o_parity_en_q               : latched frame data and parity option
//   o_load, o_shift_en                    : shift-register load and shift strobes
//   o_select                              : mux select (SEL_* codes)
//   o_busy, o_tx_done                     : frame in progress / last stop-bit cycle
//
// state     | meaning
// ----------+-------------------------------------------------
// TX_IDLE   | line idle-high, waiting for i_tx_start
// TX_START  | start bit; shift register loaded on the first cycle
// TX_DATA   | DATA_W data bits, LSB first, indexed by r_bit_idx
// TX_PARITY | parity bit (only when the latched parity enable is set)
// TX_STOP   | stop bit; o_tx_done on its last cycle
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_tx_start,
  input  logic [DATA_W-1:0] i_tx_data_in,
  input  logic              i_parity_en,
  output logic [DATA_W-1:0] o_data_q,
  output logic              o_parity_en_q,
  output logic              o_load,
  output logic              o_shift_en,
  output logic [1:0]        o_select,
  output logic              o_busy,
  output logic              o_tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  tx_state_t         r_state;
  logic [DATA_W-1:0] r_data_q;
  logic              r_parity_en_q;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [1:0]        r_select;
  logic              r_busy;

  logic [CNT_W-1:0]  w_baud_cnt;
  logic              w_bit_end;
  logic              w_idle;

  assign w_idle = (r_state == TX_IDLE);

  // Holding the counter in clear while idle guarantees every frame starts at count 0.
  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (w_idle),
    .i_run    (!w_idle),
    .o_count  (w_baud_cnt),
    .o_bit_end(w_bit_end)
  );

  // o_select and o_busy are registered together with the state, so they change on the
  // same edge as the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= TX_IDLE;
      r_data_q      <= '0;
      r_parity_en_q <= 1'b0;
      r_bit_idx     <= '0;
      r_select      <= SEL_STOP;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        TX_IDLE: begin
          if (i_tx_start) begin
            r_data_q      <= i_tx_data_in;
            r_parity_en_q <= i_parity_en;
            r_state       <= TX_START;
            r_select      <= SEL_START;
            r_busy        <= 1'b1;
          end
        end
        TX_START: begin
          if (w_bit_end) begin
            r_state   <= TX_DATA;
            r_bit_idx <= '0;
            r_select  <= SEL_DATA;
          end
        end
        TX_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == IDX_LAST) begin
              r_state  <= r_parity_en_q ? TX_PARITY : TX_STOP;
              r_select <= r_parity_en_q ? SEL_PAR : SEL_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        TX_PARITY: begin
          if (w_bit_end) begin
            r_state  <= TX_STOP;
            r_select <= SEL_STOP;
          end
        end
        TX_STOP: begin
          if (w_bit_end) begin
            r_state  <= TX_IDLE;
            r_busy   <= 1'b0;
            r_select <= SEL_STOP;
          end
        end
        default: begin
          r_state  <= TX_IDLE;
          r_busy   <= 1'b0;
          r_select <= SEL_STOP;
        end
      endcase
    end
  end

  // The shift at the end of START presents data bit 0; no shift after the last data bit,
  // which gives exactly DATA_W shifts per frame.
  assign o_load     = (r_state == TX_START) && (w_baud_cnt == '0);
  assign o_shift_en = w_bit_end &&
                      ((r_state == TX_START) ||
                       ((r_state == TX_DATA) && (r_bit_idx != IDX_LAST)));
  assign o_tx_done  = (r_state == TX_STOP) && w_bit_end;

  assign o_data_q      = r_data_q;
  assign o_parity_en_q = r_parity_en_q;
  assign o_select      = r_select;
  assign o_busy        = r_busy;

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Sequencing controller for the UART transmit datapath. Accepts one byte per `tx_start` handshake, latches the byte and the parity option, and drives the existing datapath blocks: the parallel-in/serial-out shift register (`load`, shift enable), the parity generator (enable and data), and the 4-way transmit mux (`select`). It generates bit timing from a clock divider and reports `busy` and `tx_done` to the bus-side logic. It sits between the UART register interface and the transmit datapath, inside the top-level `transmitter`.

## Interface
Parameters:
- `DATA_W`, default 8: frame data width, also the shift-register width.
- `CLKS_PER_BIT`, default 16: `clk` cycles per serial bit. Must be ≥ 2.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_start`  in  1  request to send. Sampled only in IDLE.
- `tx_data_in`  in  DATA_W  byte to send. Sampled on accept.
- `parity_en`  in  1  include a parity bit in the frame. Sampled on accept.
- `data_q`  out  DATA_W  latched frame data. Drives the shift-register `data_in` and the parity-generator `data`.
- `parity_en_q`  out  1  latched parity enable. Drives the parity generator.
- `load`  out  1  shift-register parallel load.
- `shift_en`  out  1  shift-register one-bit shift strobe.
- `select`  out  2  mux select: 00 start, 01 data, 10 parity, 11 stop/idle.
- `busy`  out  1  high while a frame is in progress.
- `tx_done`  out  1  one-cycle pulse on the last cycle of the stop bit.

## Operation
- State machine states: IDLE, START, DATA, PARITY, STOP.
- Counters:
  - `baud_cnt` runs 0..CLKS_PER_BIT-1 in every non-IDLE state, then wraps to 0.
  - `bit_idx` runs 0..DATA_W-1 in DATA.
- A "bit end" is the cycle where `baud_cnt == CLKS_PER_BIT-1`.
- Accept: when in IDLE and `tx_start==1` at a clock edge:
  - `data_q <= tx_data_in`, `parity_en_q <= parity_en`.
  - `baud_cnt <= 0`, state becomes START.
- Transitions, each taken only at bit end:
  - START → DATA, with `bit_idx = 0`.
  - DATA with `bit_idx < DATA_W-1` → DATA, with `bit_idx` incremented.
  - DATA with `bit_idx == DATA_W-1` → PARITY if `parity_en_q`, else STOP.
  - PARITY → STOP.
  - STOP → IDLE.
- Outputs are decoded from registered state and counters only (Moore):
  - `select`: IDLE=11, START=00, DATA=01, PARITY=10, STOP=11.
  - `busy = (state != IDLE)`.
  - `load = START && baud_cnt==0`.
  - `shift_en` is high at bit end when in START, or in DATA with `bit_idx < DATA_W-1`. This gives exactly DATA_W shifts per frame; LSB first.
  - `tx_done = STOP && bit end`.
- `tx_start` while busy is ignored, not queued. `tx_data_in` and `parity_en` changes mid-frame have no effect.
- Reset values: state IDLE, `data_q=0`, `parity_en_q=0`, counters 0. Resulting outputs: `select=11`, `busy=0`, `load=0`, `shift_en=0`, `tx_done=0`.
- Reset mid-frame returns everything to these values immediately. The line goes to idle-high via `select=11`.

## Timing
- Latency: `tx_start` sampled at edge k → `busy` and `select=00` from edge k.
  - `load` is high for cycle k..k+1; the shift register captures `data_q` at edge k+1.
  - The first data bit appears on the mux at edge k+CLKS_PER_BIT.
- Frame length:
  - (DATA_W+3)·CLKS_PER_BIT cycles with parity.
  - (DATA_W+2)·CLKS_PER_BIT cycles without parity.
- Each `select` value holds for exactly CLKS_PER_BIT cycles per bit.
- `tx_done` and the STOP→IDLE transition share one edge.
- Back-to-back: `tx_start` is not accepted in the `tx_done` cycle. There is a minimum of one IDLE cycle (`select=11`) between frames.
- `load` and `shift_en` are never high in the same cycle (guaranteed by CLKS_PER_BIT ≥ 2).

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `tx_state_t`;
  - select constants `SEL_START=2'b00`, `SEL_DATA=2'b01`, `SEL_PAR=2'b10`, `SEL_STOP=2'b11`.
  The receiver and the mux use the same constants.
- One sub-module, `uart_baud_cnt`. It is parameterised by CLKS_PER_BIT, with inputs `clk`, `rst_n`, `clear`, `run` and outputs `bit_end` and the count. It is reused by the receiver.
- The FSM, `bit_idx` counter and latches live in `uart_tx_ctrl`.

## Test plan
All scenarios use CLKS_PER_BIT=4, DATA_W=8, with the real shift register, parity generator and mux attached.
- Send 8'hA5 with parity on:
  - `busy` high for exactly 44 cycles; 8 `shift_en` pulses; one `tx_done`.
  - `select` sequence is 00×4, 01×32, 10×4, 11×4.
  - Serial bits are 0, 1,0,1,0,0,1,0,1, 0, 1 (parity 0).
- Send 8'h07 with parity off:
  - 40-cycle frame; `select` never equals 10.
  - Serial bits are 0, 1,1,1,0,0,0,0,0, 1.
- Pulse `tx_start` with new data and toggle `tx_data_in` during DATA:
  - The ongoing frame is unchanged and `data_q` is stable.
  - No second frame starts.
- Hold `tx_start` high continuously:
  - Consecutive frames are separated by exactly one cycle with `busy=0` and `select=11`.
- Assert `rst_n=0` in the middle of DATA:
  - Same-cycle outputs are `busy=0`, `select=11`, `load=0`, `shift_en=0`, `tx_done=0`.
  - After release, a new `tx_start` sends a full, correct frame.
